// File: rtl/decode_stage.sv
// Registered multi-lane decode stage: a circular instruction queue feeding a
// WIDTH-wide decoded-uop output register with valid/ready, exception halt and flush.

package Instr;
  typedef logic [31:0] enc_t;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_REG = 7'b0110011;
endpackage

package Uop;
  typedef enum logic [1:0] {FU_NONE, FU_INTALU, FU_MEM} fu_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } op_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} sz_t;
  typedef enum logic {EX_NONE, EX_DECODE} ex_t;

  typedef struct packed {
    logic isLd;
    logic isSt;
    logic isUns;
    sz_t  sz;
  } mem_op_t;

  typedef struct packed {
    fu_t         fu;
    op_t         op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        immValid;
    mem_op_t     memOp;
    logic        exValid;
    ex_t         ex;
  } dec_t;

  function automatic dec_t decode(Instr::enc_t w);
    dec_t d;
    logic bad;
    d = '0;
    bad = 1'b0;
    case (w[6:0])
      Instr::OP_IMM: begin
        d.fu = FU_INTALU;
        d.rs1 = w[19:15];
        d.rd = w[11:7];
        d.immValid = 1'b1;
        d.imm = {{20{w[31]}}, w[31:20]};
        case (w[14:12])
          3'b000: d.op = ALU_ADD;
          3'b001: begin d.op = ALU_SLL; d.imm = {27'b0, w[24:20]}; end
          3'b010: d.op = ALU_SLT;
          3'b011: d.op = ALU_SLTU;
          3'b100: d.op = ALU_XOR;
          3'b101: begin d.op = w[30] ? ALU_SRA : ALU_SRL; d.imm = {27'b0, w[24:20]}; end
          3'b110: d.op = ALU_OR;
          default: d.op = ALU_AND;
        endcase
      end
      Instr::OP_REG: begin
        d.fu = FU_INTALU;
        d.rs1 = w[19:15];
        d.rs2 = w[24:20];
        d.rd = w[11:7];
        case (w[14:12])
          3'b000: d.op = w[30] ? ALU_SUB : ALU_ADD;
          3'b001: d.op = ALU_SLL;
          3'b010: d.op = ALU_SLT;
          3'b011: d.op = ALU_SLTU;
          3'b100: d.op = ALU_XOR;
          3'b101: d.op = w[30] ? ALU_SRA : ALU_SRL;
          3'b110: d.op = ALU_OR;
          default: d.op = ALU_AND;
        endcase
      end
      Instr::OP_LD: begin
        d.fu = FU_MEM;
        d.op = ALU_ADD;
        d.rs1 = w[19:15];
        d.rd = w[11:7];
        d.immValid = 1'b1;
        d.imm = {{20{w[31]}}, w[31:20]};
        d.memOp.isLd = 1'b1;
        case (w[14:12])
          3'b000: d.memOp.sz = SZ_B;
          3'b001: d.memOp.sz = SZ_H;
          3'b010: d.memOp.sz = SZ_W;
          3'b100: begin d.memOp.sz = SZ_B; d.memOp.isUns = 1'b1; end
          3'b101: begin d.memOp.sz = SZ_H; d.memOp.isUns = 1'b1; end
          default: bad = 1'b1;
        endcase
      end
      Instr::OP_ST: begin
        d.fu = FU_MEM;
        d.op = ALU_ADD;
        d.rs1 = w[19:15];
        d.rs2 = w[24:20];
        d.immValid = 1'b1;
        d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
        d.memOp.isSt = 1'b1;
        case (w[14:12])
          3'b000: d.memOp.sz = SZ_B;
          3'b001: d.memOp.sz = SZ_H;
          3'b010: d.memOp.sz = SZ_W;
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    // A faulting uop carries nothing but the exception itself.
    if (bad) begin
      d = '0;
      d.exValid = 1'b1;
      d.ex = EX_DECODE;
    end
    return d;
  endfunction
endpackage

module decode_stage #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   flush,
  input  logic                   fetchValid,
  input  logic [WIDTH-1:0]       fetchLaneValid,
  input  logic [WIDTH-1:0][31:0] fetchEnc,
  output logic                   fetchReady,
  output logic [WIDTH-1:0]       decValid,
  output Uop::dec_t [WIDTH-1:0]  dec,
  input  logic                   decReady,
  output logic                   halted
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, HALT} state_t;
  state_t state, stateNext;

  Instr::enc_t           mem [DEPTH];
  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         count;
  logic                  push, load, hitEx;
  logic [CW-1:0]         pushCnt, popCnt;
  logic [PW-1:0]         laneOff [WIDTH];
  logic [WIDTH-1:0]      popValid;
  Uop::dec_t [WIDTH-1:0] popDec;

  assign fetchReady = (count <= CW'(DEPTH - WIDTH));
  assign push = fetchValid && fetchReady && !flush;
  assign load = (!decValid[0] || decReady) && (state == RUN);
  assign halted = (state == HALT);

  // Valid fetch lanes are packed toward the tail in lane order.
  always_comb begin
    pushCnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      laneOff[i] = PW'(pushCnt);
      pushCnt = pushCnt + CW'(fetchLaneValid[i]);
    end
  end

  // Peek at the oldest entries; stop just after the first faulting lane.
  always_comb begin
    popValid = '0;
    popDec = '0;
    popCnt = '0;
    hitEx = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!hitEx && (CW'(i) < count)) begin
        popDec[i] = Uop::decode(mem[head + PW'(i)]);
        popValid[i] = 1'b1;
        popCnt = popCnt + CW'(1);
        hitEx = popDec[i].exValid;
      end
    end
  end

  always_comb begin
    stateNext = state;
    if (flush)
      stateNext = RUN;
    else if (load && hitEx)
      stateNext = HALT;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)
      state <= RUN;
    else
      state <= stateNext;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push)
        tail <= tail + PW'(pushCnt);
      if (load)
        head <= head + PW'(popCnt);
      count <= count + (push ? pushCnt : '0) - (load ? popCnt : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      for (int i = 0; i < WIDTH; i++)
        if (fetchLaneValid[i])
          mem[tail + laneOff[i]] <= fetchEnc[i];
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      decValid <= '0;
      dec <= '0;
    end else if (flush || (halted && decReady)) begin
      decValid <= '0;
      dec <= '0;
    end else if (load) begin
      decValid <= popValid;
      dec <= popDec;
    end
  end

endmodule
